if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch front end and the consumer side of pc_reg.
- Reads the current pc, issues one read at a time to instruction memory over a req/gnt/rvalid handshake, and presents the fetched word to decode with valid/ready.
- Drives pc_next back into pc_reg: hold, pc+4 on accept, or redirect target.

Parameters:
- XLEN, 32, pc/address width.
- ILEN, 32, instruction width.
- PC_STEP, 4, increment applied on instruction accept.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  XLEN  current pc from pc_reg.
- pc_next  out  XLEN  next pc to pc_reg.
- imem_req  out  1  read request.
- imem_addr  out  XLEN  read address; always equals pc.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  ILEN  read data.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  XLEN  redirect target.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts.
- instr  out  ILEN  fetched instruction.
- instr_pc  out  XLEN  pc of the presented instruction.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset (while rst=1):
  - state=IDLE, imem_req=0, instr_valid=0.
  - instr=0, instr_pc=0, pc_next=pc.
  - Instruction memory shares rst, so no stale rvalid is expected after reset.
- FSM states: IDLE, REQ, WAIT, HOLD, DROP.
  - IDLE -> REQ on the first cycle after rst deasserts.
  - REQ: imem_req=1, imem_addr=pc.
    - gnt=1 -> WAIT.
    - Address may change before gnt (redirect).
  - WAIT: imem_req=0.
    - rvalid=1 -> capture imem_rdata into instr and pc into instr_pc -> HOLD.
  - HOLD: instr_valid=1.
    - instr_ready=1 -> pc_next=pc+PC_STEP -> REQ; the new pc is used next cycle.
  - DROP: an outstanding response is unwanted.
    - imem_req=0.
    - rvalid=1 -> discard -> REQ.
- pc_next priority:
  1. redirect_valid: pc_next = {redirect_pc[XLEN-1:2], 2'b00}.
  2. Accept (instr_valid & instr_ready): pc_next = pc+PC_STEP, modulo 2^XLEN; 0xFFFFFFFC wraps to 0.
  3. Otherwise pc_next=pc (stall).
- Redirect by state:
  - IDLE/REQ without gnt -> REQ.
  - REQ with gnt same cycle -> DROP.
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid -> data discarded -> REQ.
  - HOLD -> instr_valid drops next cycle, instr_ready ignored (no accept) -> REQ.
  - DROP -> remains DROP, target updated.
- Exactly one outstanding request. No new req while in WAIT or DROP.
- instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.
- Latency with zero-wait memory (gnt same cycle, rvalid next cycle): 3 cycles per instruction.

Optional Feature:
- Macro IF_BYPASS_EN.
- Defined:
  - In WAIT with rvalid=1, instr_valid=1 combinationally, with instr=imem_rdata and instr_pc=pc.
  - If instr_ready=1 in that cycle: accept, pc_next=pc+4, -> REQ with no HOLD cycle (2 cycles/instr).
  - Otherwise capture -> HOLD as normal.
  - A redirect in that cycle suppresses instr_valid.
- Undefined: outputs are always registered as described above.

Decomposition:
- Package if_pkg:
  - state enum (IDLE, REQ, WAIT, HOLD, DROP).
  - PC_STEP and ILEN/XLEN defaults.
  - NOP encoding 32'h00000013, used by benches for stall fill.
- One natural sub-module: if_instr_hold, the instr/instr_pc holding register with load/clear.

Test Plan:
- Reset then zero-wait memory returning 0x00000013 @0, 0x00100093 @4, ready=1:
  - instr_pc 0 then 4.
  - pc_next 4 then 8.
  - 3-cycle spacing (2 with IF_BYPASS_EN).
- gnt delayed 3 cycles, rvalid delayed 2:
  - imem_req held at addr 0 until gnt.
  - instr_valid only after rvalid.
  - pc_next=pc throughout.
- instr_ready=0 for 4 cycles in HOLD:
  - instr/instr_pc stable, pc_next=pc.
  - On ready=1, pc_next=pc+4.
- redirect_valid with redirect_pc=0x00000022 while in WAIT:
  - pc_next=0x00000020.
  - Late rvalid data never appears on instr.
  - Next req addr=0x20.
- Redirect in HOLD with ready=1 the same cycle:
  - Instruction not accepted.
  - pc_next=redirect target.
- rst asserted mid-WAIT:
  - Next cycle imem_req=0, instr_valid=0.
  - Fetch restarts at pc=0.

Source files
------------

// File: rtl/if_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_pkg : shared types and defaults for the instruction-fetch stage    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package if_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ILEN_DEF    = 32;
  localparam int PC_STEP_DEF = 4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } if_state_e;

endpackage : if_pkg
`default_nettype wire

// File: rtl/if_instr_hold.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_instr_hold : instruction / pc holding register with load and clear |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module if_instr_hold
  import if_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [ILEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [ILEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out
);

  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear) begin
      instr_d = '0;
      pc_d    = '0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;

endmodule : if_instr_hold
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch : single-outstanding instruction fetch front end             |
// | Optional IF_BYPASS_EN presents rvalid data to decode in the same cycle|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module if_fetch
  import if_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ILEN    = ILEN_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  if_state_e       state_q, state_d;
  logic            hold_load;
  logic            hold_clear;
  logic            accept;
  logic            byp_valid;
  logic [XLEN-1:0] redirect_tgt;
  logic [ILEN-1:0] held_instr;
  logic [XLEN-1:0] held_pc;

  assign imem_addr    = pc;
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef IF_BYPASS_EN
  assign byp_valid = (state_q == WAIT) & imem_rvalid & ~redirect_valid & ~rst;
`else
  assign byp_valid = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    accept      = 1'b0;
    pc_next     = pc;
    instr       = held_instr;
    instr_pc    = held_pc;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        // a redirect racing the grant leaves a response that must be dropped
        if (imem_gnt) state_d = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            state_d = REQ;
          end else if (byp_valid && instr_ready) begin
            state_d = REQ;
          end else begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end
        end else if (redirect_valid) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (redirect_valid) begin
          hold_clear = 1'b1;
          state_d    = REQ;
        end else if (instr_ready) begin
          state_d = REQ;
        end
      end
      DROP: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase

    instr_valid = instr_valid | byp_valid;
    if (byp_valid) begin
      instr    = imem_rdata;
      instr_pc = pc;
    end
    accept = instr_valid & instr_ready & ~redirect_valid;

    if (redirect_valid)  pc_next = redirect_tgt;
    else if (accept)     pc_next = pc + XLEN'(PC_STEP);

    if (rst) begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      hold_load   = 1'b0;
      hold_clear  = 1'b0;
      instr       = '0;
      instr_pc    = '0;
      pc_next     = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  if_instr_hold #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .instr_in  (imem_rdata),
    .pc_in     (pc),
    .instr_out (held_instr),
    .pc_out    (held_pc)
  );

endmodule : if_fetch
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_fetch : randomized self-checking bench for if_fetch             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_if_fetch;

`ifdef IF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] pc_next, imem_addr, instr, instr_pc;
  logic        imem_req, instr_valid;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // abstract fetch model: started / response outstanding / response wanted / holding
  bit          m_started, m_out, m_want, m_held;
  logic [31:0] m_instr, m_ipc, m_pc;
  bit          n_started, n_out, n_want, n_held;
  logic [31:0] n_instr, n_ipc, n_pc;

  // memory and stimulus knobs
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt, req_cycles, cur_gnt_lat;
  int          gnt_lat, rv_lat, ready_pct, redir_pct;
  bit          rand_lat, rand_rst, rst_drv;
  bit          redir_wait_once, redir_hold_once, rst_wait_once;
  bit          redir_wait_hit, redir_hold_hit, rst_wait_hit;
  int          redir_wait_cyc, redir_hold_cyc;
  logic [31:0] pcn_at_wait_redir, pcn_at_hold_redir;
  int          req_run;

  logic [31:0] acc_pc[$], acc_instr[$], acc_pcn[$], grant_addr[$];
  int          acc_cyc[$], grant_run[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_and_model();
    bit          byp_v, exp_req, exp_valid, acc;
    logic [31:0] exp_instr, exp_ipc, exp_pcn, tgt;
    tgt       = {redirect_pc[31:2], 2'b00};
    exp_req   = !rst && m_started && !m_out && !m_held;
    byp_v     = BYP && !rst && m_out && m_want && imem_rvalid && !redirect_valid;
    exp_valid = !rst && (m_held || byp_v);
    exp_instr = rst ? 32'h0 : (byp_v ? imem_rdata : m_instr);
    exp_ipc   = rst ? 32'h0 : (byp_v ? m_pc : m_ipc);
    acc       = exp_valid && instr_ready && !redirect_valid;
    if (rst)                 exp_pcn = m_pc;
    else if (redirect_valid) exp_pcn = tgt;
    else if (acc)            exp_pcn = m_pc + 32'd4;
    else                     exp_pcn = m_pc;

    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    if (exp_valid || rst) begin
      chk("instr", instr, exp_instr);
      chk("instr_pc", instr_pc, exp_ipc);
    end
    chk("pc_next", pc_next, exp_pcn);

    if (rst) begin
      acc_pc.delete(); acc_instr.delete(); acc_pcn.delete(); acc_cyc.delete();
      grant_addr.delete(); grant_run.delete();
      req_run = 0;
    end else begin
      if (instr_valid && instr_ready && !redirect_valid) begin
        acc_pc.push_back(instr_pc); acc_instr.push_back(instr);
        acc_pcn.push_back(pc_next); acc_cyc.push_back(cyc);
      end
      if (imem_req) req_run++;
      if (imem_req && imem_gnt) begin
        grant_addr.push_back(imem_addr); grant_run.push_back(req_run);
        req_run     = 0;
        mem_pend    = 1'b1;
        mem_addr    = imem_addr;
        mem_cnt     = rand_lat ? int'($urandom_range(0, 3)) : rv_lat;
        req_cycles  = 0;
        cur_gnt_lat = rand_lat ? int'($urandom_range(0, 3)) : gnt_lat;
      end
    end
    if (redir_wait_hit && cyc == redir_wait_cyc) pcn_at_wait_redir = pc_next;
    if (redir_hold_hit && cyc == redir_hold_cyc) pcn_at_hold_redir = pc_next;

    n_started = m_started; n_out = m_out; n_want = m_want; n_held = m_held;
    n_instr = m_instr; n_ipc = m_ipc;
    if (rst) begin
      n_started = 0; n_out = 0; n_want = 0; n_held = 0;
      n_instr = '0; n_ipc = '0;
    end else if (!m_started) begin
      n_started = 1;
    end else if (m_held) begin
      if (redirect_valid || acc) n_held = 0;
    end else if (m_out) begin
      if (imem_rvalid) begin
        n_out = 0;
        if (m_want && !redirect_valid && !acc) begin
          n_held = 1; n_instr = imem_rdata; n_ipc = m_pc;
        end
      end else if (redirect_valid) begin
        n_want = 0;
      end
    end else if (imem_gnt) begin
      n_out  = 1;
      n_want = !redirect_valid;
    end
    n_pc = rst ? 32'h0 : exp_pcn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    m_started = n_started; m_out = n_out; m_want = n_want; m_held = n_held;
    m_instr = n_instr; m_ipc = n_ipc; m_pc = n_pc;
    pc = m_pc;
    if (rst) begin
      mem_pend   = 1'b0;
      req_cycles = 0;
    end
    rst = rst_drv;
    if (rand_rst && $urandom_range(0, 399) == 0) rst = 1'b1;
    if (rst_wait_once && m_out && !rst) begin
      rst = 1'b1; rst_wait_once = 0; rst_wait_hit = 1;
    end

    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!rst && mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pend    = 1'b0;
      end else begin
        mem_cnt--;
      end
    end

    imem_gnt = 1'b0;
    if (!rst && imem_req) begin
      if (req_cycles >= cur_gnt_lat) imem_gnt = 1'b1;
      req_cycles++;
    end

    instr_ready    = ($urandom_range(0, 99) < ready_pct);
    redirect_valid = ($urandom_range(0, 99) < redir_pct);
    redirect_pc    = $urandom;
    if (!rst && redir_wait_once && m_out && m_want && !imem_rvalid) begin
      redirect_valid = 1'b1; redirect_pc = 32'h22;
      redir_wait_once = 0; redir_wait_hit = 1; redir_wait_cyc = cyc;
    end
    if (!rst && redir_hold_once && m_held) begin
      redirect_valid = 1'b1; redirect_pc = 32'h100; instr_ready = 1'b1;
      redir_hold_once = 0; redir_hold_hit = 1; redir_hold_cyc = cyc;
    end

    @(negedge clk);
    check_and_model();
  endtask

  task automatic reset_pulse(input int n);
    rst_drv = 1;
    repeat (n) step();
    rst_drv = 0;
  endtask

  task automatic knobs(input int g, input int r, input int rdy, input int rd);
    gnt_lat = g; rv_lat = r; ready_pct = rdy; redir_pct = rd;
    cur_gnt_lat = g; rand_lat = 0;
  endtask

  initial begin
    rst_drv = 1;
    knobs(0, 0, 100, 0);
    rand_rst = 0;

    // zero-wait memory, two back-to-back instructions
    reset_pulse(3);
    repeat (8) step();
    chk("p1_accept_count", 32'(acc_pc.size() >= 2), 32'd1);
    if (acc_pc.size() >= 2) begin
      chk("p1_pc0", acc_pc[0], 32'h0);
      chk("p1_instr0", acc_instr[0], 32'h0000_0013);
      chk("p1_pcnext0", acc_pcn[0], 32'h4);
      chk("p1_pc1", acc_pc[1], 32'h4);
      chk("p1_instr1", acc_instr[1], 32'h0010_0093);
      chk("p1_pcnext1", acc_pcn[1], 32'h8);
      chk("p1_spacing", 32'(acc_cyc[1] - acc_cyc[0]), BYP ? 32'd2 : 32'd3);
    end

    // slow grant and slow response
    knobs(3, 2, 100, 0);
    reset_pulse(2);
    repeat (24) step();
    chk("p2_grant_seen", 32'(grant_addr.size() >= 1), 32'd1);
    if (grant_addr.size() >= 1) begin
      chk("p2_grant_addr", grant_addr[0], 32'h0);
      chk("p2_req_cycles", 32'(grant_run[0]), 32'd4);
    end

    // decode back-pressure while holding
    knobs(0, 0, 0, 0);
    repeat (10) step();
    ready_pct = 100;
    repeat (4) step();

    // redirect while waiting for a response
    knobs(0, 3, 100, 0);
    reset_pulse(2);
    redir_wait_once = 1;
    repeat (20) step();
    chk("p4_redirect_hit", 32'(redir_wait_hit), 32'd1);
    chk("p4_pcnext", pcn_at_wait_redir, 32'h20);
    chk("p4_grants", 32'(grant_addr.size() >= 2), 32'd1);
    if (grant_addr.size() >= 2) chk("p4_new_addr", grant_addr[1], 32'h20);
    chk("p4_accepts", 32'(acc_pc.size() >= 1), 32'd1);
    if (acc_pc.size() >= 1) chk("p4_first_pc", acc_pc[0], 32'h20);

    // redirect while holding, with ready asserted the same cycle
    knobs(0, 0, 50, 0);
    redir_hold_once = 1;
    repeat (30) step();
    chk("p5_redirect_hit", 32'(redir_hold_hit), 32'd1);
    chk("p5_pcnext", pcn_at_hold_redir, 32'h100);

    // reset in the middle of a wait
    knobs(0, 3, 100, 0);
    rst_wait_once = 1;
    repeat (16) step();
    chk("p6_reset_hit", 32'(rst_wait_hit), 32'd1);
    chk("p6_grants", 32'(grant_addr.size() >= 1), 32'd1);
    if (grant_addr.size() >= 1) chk("p6_restart_addr", grant_addr[0], 32'h0);

    // randomized mix
    knobs(0, 0, 70, 8);
    rand_lat = 1;
    rand_rst = 1;
    repeat (3000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_fetch
`default_nettype wire
